// File: rtl/sr_reg_bank.sv
// Bank of WIDTH clocked SR storage channels with selectable S=R=1 resolution
// and conflict tracking (per-channel mask, pulse, sticky flag, saturating count).
module sr_reg_bank #(
    parameter int unsigned           WIDTH   = 8,
    parameter int unsigned           CNT_W   = 8,
    parameter logic [WIDTH-1:0]      RESET_Q = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       mode,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] conflict_mask,
    output logic             conflict,
    output logic             conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_SET    = 2'd1,
        MODE_RESET  = 2'd2,
        MODE_TOGGLE = 2'd3
    } res_mode_e;

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] both;
    logic             hit;
    logic             conf_now;
    res_mode_e        res_mode;

    assign both     = s & r;
    assign hit      = |both;
    assign conf_now = en & hit;
    assign res_mode = res_mode_e'(mode);

    always_comb begin
        next_q = q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({s[i], r[i]})
                2'b00: next_q[i] = q[i];
                2'b01: next_q[i] = 1'b0;
                2'b10: next_q[i] = 1'b1;
                default: begin
                    unique case (res_mode)
                        MODE_HOLD:   next_q[i] = q[i];
                        MODE_SET:    next_q[i] = 1'b1;
                        MODE_RESET:  next_q[i] = 1'b0;
                        MODE_TOGGLE: next_q[i] = ~q[i];
                        default:     next_q[i] = q[i];
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q             <= RESET_Q;
            q_rise        <= '0;
            conflict_mask <= '0;
            conflict      <= 1'b0;
        end else if (en) begin
            q             <= next_q;
            q_rise        <= next_q & ~q;
            conflict_mask <= both;
            conflict      <= hit;
        end else begin
            q_rise        <= '0;
            conflict_mask <= '0;
            conflict      <= 1'b0;
        end
    end

    // A conflict on the same edge as a clear is kept so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else if (clr_err) begin
            conflict_sticky <= conf_now;
            conflict_cnt    <= conf_now ? CNT_W'(1) : '0;
        end else if (conf_now) begin
            conflict_sticky <= 1'b1;
            if (conflict_cnt != {CNT_W{1'b1}})
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: one 8-bit counter instance with RESET_Q=A5
// and one 2-bit counter instance sharing the same stimulus for saturation.
module tb_sr_reg_bank;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [1:0]   mode;
    logic         clr_err;

    logic [W-1:0] q, qbar, q_rise, conflict_mask;
    logic         conflict, conflict_sticky;
    logic [7:0]   conflict_cnt;

    logic [W-1:0] q2, qbar2, q_rise2, conflict_mask2;
    logic         conflict2, conflict_sticky2;
    logic [1:0]   conflict_cnt2;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    sr_reg_bank #(.WIDTH(W), .CNT_W(8), .RESET_Q(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .mode(mode), .clr_err(clr_err),
        .q(q), .qbar(qbar), .q_rise(q_rise), .conflict_mask(conflict_mask),
        .conflict(conflict), .conflict_sticky(conflict_sticky), .conflict_cnt(conflict_cnt)
    );

    sr_reg_bank #(.WIDTH(W), .CNT_W(2), .RESET_Q(8'hA5)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .mode(mode), .clr_err(clr_err),
        .q(q2), .qbar(qbar2), .q_rise(q_rise2), .conflict_mask(conflict_mask2),
        .conflict(conflict2), .conflict_sticky(conflict_sticky2), .conflict_cnt(conflict_cnt2)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic e, input logic [W-1:0] sv, input logic [W-1:0] rv,
                         input logic [1:0] m, input logic c);
        en = e; s = sv; r = rv; mode = m; clr_err = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 2'd0, 1'b0);
        step();
        check("rst_q", q, 8'hA5);
        check("rst_qbar", qbar, 8'h5A);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_sticky", conflict_sticky, 0);
        rst = 1'b0;

        // idle enabled cycles keep reset value
        drive(1'b1, '0, '0, 2'd0, 1'b0);
        repeat (3) step();
        check("idle_q", q, 8'hA5);
        check("idle_qbar", qbar, 8'h5A);
        check("idle_rise", q_rise, 0);
        check("idle_mask", conflict_mask, 0);
        check("idle_conf", conflict, 0);
        check("idle_cnt", conflict_cnt, 0);

        // clear all, then mixed set/reset
        drive(1'b1, '0, 8'hFF, 2'd0, 1'b0); step();
        check("clr_q", q, 8'h00);
        drive(1'b1, 8'h0F, 8'hF0, 2'd0, 1'b0); step();
        check("sr_q", q, 8'h0F);
        check("sr_rise", q_rise, 8'h0F);
        check("sr_conf", conflict, 0);
        drive(1'b1, '0, '0, 2'd0, 1'b0); step();
        check("sr_q_hold", q, 8'h0F);
        check("sr_rise_drop", q_rise, 8'h00);

        // resolution modes on channel 0
        drive(1'b1, '0, 8'hFF, 2'd0, 1'b0); step();
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 8'h01, 8'h01, 2'(m), 1'b0); step();
            check($sformatf("mode%0d_q", m), q, (m % 2 == 1) ? 8'h01 : 8'h00);
            check($sformatf("mode%0d_mask", m), conflict_mask, 8'h01);
            check($sformatf("mode%0d_conf", m), conflict, 1);
        end
        check("mode_cnt", conflict_cnt, 4);
        check("mode_sticky", conflict_sticky, 1);
        check("mode_cnt_sat", conflict_cnt2, 3);

        // clear alone
        drive(1'b1, '0, '0, 2'd0, 1'b1); step();
        check("clr_cnt", conflict_cnt, 0);
        check("clr_sticky", conflict_sticky, 0);

        // saturation of the 2-bit counter
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 8'h01, 8'h01, 2'd0, 1'b0); step();
            check($sformatf("sat_cnt2_%0d", k), conflict_cnt2, (k < 3) ? k : 3);
            check($sformatf("sat_cnt_%0d", k), conflict_cnt, k);
        end
        drive(1'b1, 8'h01, 8'h01, 2'd0, 1'b1); step();
        check("clrconf_cnt2", conflict_cnt2, 1);
        check("clrconf_sticky2", conflict_sticky2, 1);
        check("clrconf_cnt", conflict_cnt, 1);
        drive(1'b1, '0, '0, 2'd0, 1'b1); step();
        check("clralone_cnt2", conflict_cnt2, 0);
        check("clralone_sticky2", conflict_sticky2, 0);

        // disabled cycles freeze q and drop pulses
        drive(1'b1, 8'h02, 8'h02, 2'd1, 1'b0); step();
        check("pre_en_cnt", conflict_cnt, 1);
        drive(1'b0, 8'hFF, 8'h00, 2'd3, 1'b0); step();
        check("dis_q", q, 8'h03);
        check("dis_conf", conflict, 0);
        check("dis_rise", q_rise, 0);
        check("dis_mask", conflict_mask, 0);
        check("dis_cnt_hold", conflict_cnt, 1);
        check("dis_sticky_hold", conflict_sticky, 1);
        drive(1'b0, 8'hFF, 8'hFF, 2'd3, 1'b1); step();
        check("dis_clr_cnt", conflict_cnt, 0);
        check("dis_clr_q", q, 8'h03);
        drive(1'b1, 8'hFF, 8'h00, 2'd3, 1'b0); step();
        check("en_q", q, 8'hFF);
        check("en_rise", q_rise, 8'hFC);

        // toggle mode flips q every enabled cycle
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        for (int k = 0; k < 3; k++) begin
            logic [W-1:0] e;
            drive(1'b1, 8'hFF, 8'hFF, 2'd3, 1'b0); step();
            e = exp_q.pop_front();
            check($sformatf("tog_q_%0d", k), q, e);
            check($sformatf("tog_rise_%0d", k), q_rise, e);
        end

        // build cnt=5 then reset on a busy edge
        drive(1'b1, '0, '0, 2'd0, 1'b1); step();
        repeat (5) begin
            drive(1'b1, 8'hFF, 8'hFF, 2'd1, 1'b0); step();
        end
        check("pre_rst_cnt", conflict_cnt, 5);
        check("pre_rst_q", q, 8'hFF);
        rst = 1'b1;
        drive(1'b1, 8'hFF, 8'h00, 2'd0, 1'b0); step();
        rst = 1'b0;
        check("busy_rst_q", q, 8'hA5);
        check("busy_rst_qbar", qbar, 8'h5A);
        check("busy_rst_cnt", conflict_cnt, 0);
        check("busy_rst_sticky", conflict_sticky, 0);
        check("busy_rst_rise", q_rise, 0);
        step();
        check("post_rst_q", q, 8'hFF);
        check("post_rst_rise", q_rise, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_reg_bank.md
# sr_reg_bank

Parametrised, clocked successor to the single-bit combinational SR latch. It holds `WIDTH` independent SR storage channels updated on the rising edge of `clk`, with a run-time-selectable resolution for the S=R=1 case instead of driving X. It also records conflicts: a per-channel mask, a sticky flag and a saturating counter. It sits between control/status sources and software-visible status registers, where set/clear event pairs must be captured glitch-free.

## Interface
Parameters:
- `WIDTH`, 8: number of SR channels (≥1).
- `CNT_W`, 8: width of the conflict counter (≥2).
- `RESET_Q`, {WIDTH{1'b0}}: value loaded into `q` on reset.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `en`  input  1  update enable; 0 freezes all state.
- `s`  input  WIDTH  per-channel set.
- `r`  input  WIDTH  per-channel reset.
- `mode`  input  2  S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
- `clr_err`  input  1  clears `conflict_sticky` and `conflict_cnt`.
- `q`  output  WIDTH  stored state.
- `qbar`  output  WIDTH  always bitwise ~q; never X.
- `q_rise`  output  WIDTH  one-cycle pulse on each channel whose `q` went 0→1 this edge.
- `conflict_mask`  output  WIDTH  registered `s & r` from the last enabled cycle.
- `conflict`  output  1  registered OR of the mask for the last enabled cycle.
- `conflict_sticky`  output  1  set by any conflict; held until cleared.
- `conflict_cnt`  output  CNT_W  count of cycles with ≥1 conflict; saturates at all-ones.

## Operation
- Reset (`rst`=1 at edge) has priority over every other input:
  - `q` = RESET_Q and `qbar` = ~RESET_Q.
  - `q_rise`, `conflict_mask`, `conflict`, `conflict_sticky` and `conflict_cnt` all = 0.
- `en`=0 at edge:
  - `q`, `conflict_sticky` and `conflict_cnt` hold.
  - `q_rise`, `conflict_mask` and `conflict` go to 0.
  - `clr_err` is still honoured.
- `en`=1 at edge, per channel i, next `q[i]` from {s[i], r[i]}:
  - 00 → hold.
  - 01 → 0.
  - 10 → 1.
  - 11 → by `mode`: 0 hold, 1 → 1, 2 → 0, 3 → ~q[i].
- `mode` is sampled every enabled edge and may change cycle to cycle; all channels use the same mode.
- `q_rise[i]` = next_q[i] & ~q[i], registered with `q`.
- `conflict_mask` = s & r; `conflict` = |(s & r).
- Counter/sticky update, in priority order:
  - `clr_err`=1 and no conflict this edge → cnt=0, sticky=0.
  - `clr_err`=1 and conflict this edge → cnt=1, sticky=1 (new event survives the clear).
  - Otherwise, a conflict → sticky=1 and cnt=cnt+1, unless cnt is all-ones (holds; no wrap).
- The counter increments once per cycle regardless of how many channels conflict.
- No combinational path from inputs to outputs; every output is a flop or ~flop.

## Timing
- Latency: inputs sampled at edge N are visible on outputs after edge N; one cycle, no pipelining.
- `q_rise` and `conflict` are single-cycle pulses unless the causing condition repeats on consecutive enabled edges.
- Reset asserted mid-operation takes effect at the next edge regardless of `en`/`s`/`r`.
  - First post-reset update happens on the first edge with `rst`=0.
- Toggle mode with S=R=1 held for k enabled cycles flips `q` k times.
  - `q_rise` pulses on every 0→1 flip.

## Test plan
- Reset with RESET_Q=8'hA5, then s=r=0, en=1 for 3 cycles → q=8'hA5, qbar=8'h5A, all flags 0, cnt=0.
- From q=8'h00, s=8'h0F, r=8'hF0 for one cycle, then zero → q=8'h0F, q_rise=8'h0F for one cycle only, conflict=0.
- s=r=8'h01 with q[0]=0, mode stepped 0,1,2,3 over four cycles → q[0] = 0,1,0,1; conflict=1 and mask=8'h01 each cycle; cnt=4, sticky=1.
- CNT_W=2, conflict held 6 cycles → cnt goes 1,2,3,3,3,3. Then clr_err with conflict → cnt=1, sticky=1. Then clr_err alone → cnt=0, sticky=0.
- en=0 with s=8'hFF, r=0 and any mode → q unchanged, conflict=0, q_rise=0. Then en=1 → q=8'hFF.
- rst asserted on the same edge as s=8'hFF and clr_err=0 while cnt=5 → q=RESET_Q, cnt=0, sticky=0, no q_rise.
